// File: rtl/prod_accumulator.sv
// prod_accumulator: sums a frame of up to N_TERMS 8-bit products and presents the result on a held handshake.
module prod_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod_in,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [4:0]       cnt_out,
  output logic             ovf_out
);
  typedef enum logic {ACC, DONE} state_t;
  state_t state, state_nx;
  logic [ACC_W-1:0] acc;
  logic [4:0] cnt;
  logic ovf, accept, close, take;
  logic [ACC_W:0] sum;
  assign accept = in_valid & (state == ACC);
  assign take   = out_ready & (state == DONE);
  assign close  = accept & (in_last | (cnt == 5'(N_TERMS - 1)));
  assign sum    = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod_in};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACC;
    else state <= state_nx;
  always_comb
    state_nx = close ? DONE : take ? ACC : state;
  always_comb begin
    in_ready  = state == ACC;
    out_valid = state == DONE;
  end
  // Clearing on take keeps the next frame starting from zero without an extra cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (take) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= sum[ACC_W-1:0];
      cnt <= cnt + 5'd1;
      ovf <= ovf | sum[ACC_W];
    end
  assign acc_out = acc;
  assign cnt_out = cnt;
  assign ovf_out = ovf;
endmodule

// File: doc/prod_accumulator.md
# prod_accumulator

Sequential multiply-accumulate back end for the 4-bit array multiplier datapath. Accepts a stream of 8-bit unsigned partial products over a valid/ready handshake and sums a frame of up to `N_TERMS` products into a wider accumulator. Presents the frame result (sum, term count, overflow flag) on a held output handshake. Sits directly downstream of the combinational multiplier: the multiplier's `prod` output drives `prod_in`.

## Interface
- `N_TERMS`, default 4: maximum products per frame; legal range 1..16.
- `ACC_W`, default 10: accumulator width; legal range 8..16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `prod_in` and `in_last` are valid.
- `in_ready` output 1: block can accept a product this cycle.
- `prod_in` input 8: unsigned product from the multiplier.
- `in_last` input 1: this product closes the frame early; sampled only on accept.
- `out_valid` output 1: frame result is available.
- `out_ready` input 1: consumer takes the result.
- `acc_out` output `ACC_W`: frame sum, modulo 2^`ACC_W`.
- `cnt_out` output 5: number of products in the frame, 1..`N_TERMS`.
- `ovf_out` output 1: at least one carry out of bit `ACC_W`-1 occurred during the frame.

## Operation
- Two states, ACC and DONE. Reset state is ACC with `acc`=0, `cnt`=0, `ovf`=0.
- `in_ready` = (state==ACC). `out_valid` = (state==DONE). Both are registered-state decodes; there is no combinational path from `in_valid` or `out_ready` to either signal.
- Accept = `in_valid` & `in_ready`. On each accept:
  - {carry, `acc`} <= `acc` + zero-extended `prod_in`, computed at `ACC_W`+1 bits.
  - `ovf` <= `ovf` | carry.
  - `cnt` <= `cnt`+1.
- Frame close: an accept with `in_last`=1, or an accept where `cnt`==`N_TERMS`-1. Either condition moves the state to DONE in the same edge that performs the add.
- In DONE:
  - `acc_out`, `cnt_out` and `ovf_out` reflect the registered `acc`, `cnt` and `ovf`, and stay stable while `out_ready`=0.
  - `prod_in` and `in_last` are ignored.
- DONE with `out_ready`=1: the next state is ACC, with `acc`, `cnt` and `ovf` cleared on the same edge.
- `in_valid` without a prior accept never changes state. An empty frame cannot be produced, so `cnt_out` is never 0 while `out_valid`=1.
- `in_last`=1 on the `N_TERMS`-th product closes the frame once; this is not an error.
- Outside DONE, `acc_out`, `cnt_out` and `ovf_out` show the running values; consumers must qualify them with `out_valid`.
- Reset asserted mid-frame or while DONE: all state clears immediately, the partial frame is discarded, and no result is emitted.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `acc_out`=0, `cnt_out`=0, `ovf_out`=0.
- Throughput: one product per cycle while in ACC.
- Latency: the closing accept at edge t gives `out_valid`=1 after edge t, i.e. valid in cycle t+1.
- Turnaround: the result is taken at edge u, `in_ready`=1 in cycle u+1. There is one dead input cycle per frame (DONE occupies at least one cycle).
- Upstream must hold `prod_in` and `in_last` stable while `in_valid`=1 and `in_ready`=0. The block holds its outputs stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset and full frame: reset, then N_TERMS=4, ACC_W=10, feed 225, 225, 225, 225 back-to-back with `out_ready`=1. Required: `out_valid` in cycle after 4th accept, `acc_out`=900, `cnt_out`=4, `ovf_out`=0, `in_ready`=1 one cycle later.
- Early close: feed 6, then 15 with `in_last`=1. Required: `acc_out`=21, `cnt_out`=2, `ovf_out`=0.
- Overflow wrap: ACC_W=9, feed four 225s. Required: `acc_out`=388 (900 mod 512), `cnt_out`=4, `ovf_out`=1. The next frame 1 with `in_last`=1 gives `acc_out`=1, `ovf_out`=0 (cleared).
- Output backpressure: complete the frame 10, 20, 30, 40 (sum 100), hold `out_ready`=0 for 5 cycles with `in_valid`=1 and `prod_in`=99. Required: outputs stable at 100 and 4, `in_ready`=0, and 99 never accumulated. Release `out_ready`; the next frame starts from 0.
- Input bubbles: random `in_valid` gaps feeding 1, 2, 3, 4. Required: `acc_out`=10, `cnt_out`=4, with no state change on idle cycles.
- Reset mid-frame: accept 50 and 60, then pulse `rst_n` low between edges. Required: immediate `acc_out`=0, `cnt_out`=0, `out_valid`=0. After release, frame 7 with `in_last` gives `acc_out`=7, `cnt_out`=1.
